// File: rtl/sync_arith_pkg.sv
// Shared opcode encoding and status-bit layout for the registered arithmetic unit.
package sync_arith_pkg;
  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_LT  = 2'd1,
    OP_SHR = 2'd2,
    OP_SM  = 2'd3
  } op_e;

  localparam int STATUS_W = 4;
  localparam int ST_ERR   = 3;
  localparam int ST_ZERO  = 2;
  localparam int ST_NEG   = 1;
  localparam int ST_ODD   = 0;
endpackage

// File: rtl/sync_arith_if.sv
// Operand/opcode request and registered result/status bundle.
interface sync_arith_if
  import sync_arith_pkg::*;
#(
  parameter int N = 2,
  parameter int M = 4
);
  logic [N-1:0]        i_op;
  logic [M-1:0]        i_arg_A;
  logic [M-1:0]        i_arg_B;
  logic [M-1:0]        o_result;
  logic [STATUS_W-1:0] o_status;

  modport master (output i_op, i_arg_A, i_arg_B, input  o_result, o_status);
  modport slave  (input  i_op, i_arg_A, i_arg_B, output o_result, o_status);
endinterface

// File: rtl/sync_arith_core.sv
// Combinational datapath: MUL / LT / SHR / sign-magnitude, producing result and error.
module sync_arith_core
  import sync_arith_pkg::*;
#(
  parameter int M = 4
) (
  input  op_e          op,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] res,
  output logic         err
);
  logic signed [2*M-1:0] prod;
  logic        [M-1:0]   neg_a;

  assign prod  = $signed(a) * $signed(b);
  assign neg_a = ~a + M'(1);

  always_comb begin
    res = '0;
    err = 1'b0;
    case (op)
      OP_MUL: begin
        // Product fits iff every bit above the result MSB equals its sign.
        if (prod[2*M-1:M-1] == {(M+1){prod[M-1]}}) res = prod[M-1:0];
        else                                       err = 1'b1;
      end
      OP_LT:  res = {{(M-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SHR: begin
        if (int'(b) >= M) res = {M{a[M-1]}};
        else              res = M'($signed(a) >>> b);
      end
      OP_SM: begin
        if (!a[M-1])                            res = a;
        else if (a == {1'b1, {(M-1){1'b0}}})    err = 1'b1;
        else                                    res = {1'b1, neg_a[M-2:0]};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/sync_arith_unit.sv
// Registered arithmetic unit: core datapath, flag generation, async-reset output stage.
module sync_arith_unit
  import sync_arith_pkg::*;
#(
  parameter int N = 2,
  parameter int M = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  sync_arith_if.slave bus
);
  logic [M-1:0]        core_res;
  logic                core_err;
  logic [M-1:0]        result_d, result_q;
  logic [STATUS_W-1:0] status_d, status_q;
  logic                unused_op;

  // Opcode bits above [1:0] are don't-care.
  assign unused_op = ^bus.i_op;

  sync_arith_core #(.M(M)) u_core (
    .op  (op_e'(bus.i_op[1:0])),
    .a   (bus.i_arg_A),
    .b   (bus.i_arg_B),
    .res (core_res),
    .err (core_err)
  );

  always_comb begin
    result_d = core_res;
    status_d = '0;
    if (core_err) begin
      result_d         = '0;
      status_d[ST_ERR] = 1'b1;
    end else begin
      status_d[ST_ZERO] = (core_res == '0);
      status_d[ST_NEG]  = core_res[M-1];
      status_d[ST_ODD]  = ^core_res;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      result_q <= '0;
      status_q <= '0;
    end else begin
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign bus.o_result = result_q;
  assign bus.o_status = status_q;
endmodule

// File: tb/tb_sync_arith_unit.sv
// Scoreboard bench for sync_arith_unit at N=2, M=4.
module tb_sync_arith_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_arith_if #(.N(2), .M(4)) bus ();

  sync_arith_unit #(.N(2), .M(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got st=%b res=%b, want st=%b res=%b", tag, got[7:4], got[3:0], exp[7:4], exp[3:0]);
    end
  endtask

  // Independent integer model: {status, result}.
  function automatic logic [7:0] model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int sa, sb, ub, p;
    logic [3:0] r;
    logic e;
    sa = $signed(a);
    sb = $signed(b);
    ub = b;
    r = 4'h0;
    e = 1'b0;
    case (op)
      2'd0: begin
        p = sa * sb;
        if (p < -8 || p > 7) e = 1'b1;
        else r = p[3:0];
      end
      2'd1: r = (sa < sb) ? 4'd1 : 4'd0;
      2'd2: begin
        if (ub >= 4) r = (sa < 0) ? 4'hF : 4'h0;
        else begin
          p = sa >>> ub;
          r = p[3:0];
        end
      end
      default: begin
        if (sa == -8) e = 1'b1;
        else if (sa < 0) begin
          p = 8 - sa;
          r = p[3:0];
        end else r = a;
      end
    endcase
    if (e) return 8'b1000_0000;
    return {1'b0, (r == 4'h0), r[3], ^r, r};
  endfunction

  task automatic sample();
    exp_t e;
    if (sb_q.size() == 0) chk("sb_empty", 8'h00, 8'hFF);
    else begin
      e = sb_q.pop_front();
      chk(e.tag, {bus.o_status, bus.o_result}, e.exp);
    end
  endtask

  // Drive at negedge, expect the result just after the next rising edge.
  task automatic vec(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                     input logic [7:0] exp, input string tag);
    exp_t e;
    bus.i_op = op; bus.i_arg_A = a; bus.i_arg_B = b;
    e.tag = tag; e.exp = exp;
    sb_q.push_back(e);
    @(posedge clk); #1;
    sample();
    @(negedge clk);
  endtask

  initial begin
    bus.i_op = 2'd0; bus.i_arg_A = 4'h0; bus.i_arg_B = 4'h0;
    repeat (2) @(negedge clk);
    chk("reset_hold", {bus.o_status, bus.o_result}, 8'h00);
    rst = 1'b0;

    vec(2'b11, 4'b0011, 4'h0, 8'b0000_0011, "sm_pre_reset");
    // Mid-cycle async reset clears immediately.
    #2 rst = 1'b1; #1;
    chk("reset_async", {bus.o_status, bus.o_result}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    vec(2'b11, 4'b0011, 4'h0, 8'b0000_0011, "sm_after_reset");

    vec(2'b01, 4'd3, 4'd5, 8'b0001_0001, "lt_3_5");
    vec(2'b01, 4'd7, 4'd4, 8'b0100_0000, "lt_7_4");
    vec(2'b01, 4'hC, 4'd3, 8'b0001_0001, "lt_m4_3");
    vec(2'b01, 4'hD, 4'hD, 8'b0100_0000, "lt_m3_m3");
    vec(2'b01, 4'd4, 4'hB, 8'b0100_0000, "lt_4_m5");

    vec(2'b11, 4'b1011, 4'h7, 8'b0011_1101, "sm_m5");
    vec(2'b11, 4'b0000, 4'h5, 8'b0100_0000, "sm_0");
    vec(2'b11, 4'b1001, 4'h0, 8'b0010_1111, "sm_m7");
    vec(2'b11, 4'b0011, 4'hF, 8'b0000_0011, "sm_3");
    vec(2'b11, 4'b1000, 4'h0, 8'b1000_0000, "sm_min_err");

    vec(2'b00, 4'd3, 4'd2, 8'b0000_0110, "mul_3_2");
    vec(2'b00, 4'hE, 4'd3, 8'b0010_1010, "mul_m2_3");
    vec(2'b00, 4'd3, 4'd3, 8'b1000_0000, "mul_ovf");
    vec(2'b00, 4'h8, 4'd1, 8'b0011_1000, "mul_m8_1");

    vec(2'b10, 4'b1000, 4'd2, 8'b0011_1110, "shr_m8_2");
    vec(2'b10, 4'b0110, 4'd1, 8'b0000_0011, "shr_6_1");
    vec(2'b10, 4'b0111, 4'd9, 8'b0100_0000, "shr_7_9");

    // Input changes between edges must not disturb the registered outputs.
    #2 bus.i_op = 2'b00; bus.i_arg_A = 4'd3; bus.i_arg_B = 4'd3; #1;
    chk("hold_between_edges", {bus.o_status, bus.o_result}, 8'b0100_0000);
    @(negedge clk);

    // Back-to-back through all ops with random operands, reset in the middle.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [3:0] a, b;
      op = 2'(i % 4);
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      vec(op, a, b, model(op, a, b), $sformatf("b2b_%0d_op%0d", i, op));
      if (i == 20) begin
        #2 rst = 1'b1; #1;
        chk("reset_mid_seq", {bus.o_status, bus.o_result}, 8'h00);
        @(posedge clk); #1;
        chk("reset_held_edge", {bus.o_status, bus.o_result}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
      end
    end

    if (sb_q.size() != 0) chk("sb_leftover", 8'(sb_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
